// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - ramp command handshake between the register layer and pwm_ramp_ctrl
interface pwm_ramp_ctrl_if #(
    parameter int BITS     = 16,
    parameter int PRE_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [BITS-1:0]     cmd_target;
    logic [BITS-1:0]     cmd_step;
    logic [PRE_BITS-1:0] cmd_pre;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output cmd_pre,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  cmd_pre,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - ramps a pwm duty_cycle to a target in clamped steps at a prescaled tick rate
// Optional abort input enabled by defining PWM_RAMP_ABORT_EN.
module pwm_ramp_ctrl #(
    parameter int BITS     = 16,
    parameter int PRE_BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    pwm_ramp_ctrl_if.slave  cmd,
    output logic [BITS-1:0] duty_cycle,
    output logic            busy,
    output logic            done
`ifdef PWM_RAMP_ABORT_EN
    ,
    input  logic            abort
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BITS-1:0]     target_q;
    logic [BITS-1:0]     step_q;
    logic [PRE_BITS-1:0] pre_q;
    logic [PRE_BITS-1:0] tick_cnt;
    logic                dir_up;

    logic                accept;
    logic                abort_in;
    logic                step_en;
    logic [BITS:0]       up_sum;
    logic [BITS-1:0]     down_gap;
    logic [BITS-1:0]     duty_nxt;

`ifdef PWM_RAMP_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state == RAMP);

    always_comb begin
        state_nxt = state;
        accept    = (state == IDLE) && cmd.cmd_valid;
        step_en   = 1'b0;
        up_sum    = {1'b0, duty_cycle} + {1'b0, step_q};
        down_gap  = duty_cycle - target_q;
        duty_nxt  = duty_cycle;
        // The extra sum bit keeps a step near full scale from wrapping before the clamp.
        if (dir_up) begin
            duty_nxt = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[BITS-1:0];
        end else begin
            duty_nxt = (down_gap <= step_q) ? target_q : (duty_cycle - step_q);
        end
        case (state)
            IDLE: begin
                if (accept && (cmd.cmd_target != duty_cycle)) begin
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (abort_in) begin
                    state_nxt = IDLE;
                end else if (tick_cnt == '0) begin
                    step_en = 1'b1;
                    if (duty_nxt == target_q) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_cycle <= '0;
            done       <= 1'b0;
            target_q   <= '0;
            step_q     <= '0;
            pre_q      <= '0;
            tick_cnt   <= '0;
            dir_up     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                target_q <= cmd.cmd_target;
                step_q   <= (cmd.cmd_step == '0) ? {{(BITS-1){1'b0}}, 1'b1} : cmd.cmd_step;
                pre_q    <= cmd.cmd_pre;
                tick_cnt <= cmd.cmd_pre;
                dir_up   <= (cmd.cmd_target > duty_cycle);
                if (cmd.cmd_target == duty_cycle) begin
                    done <= 1'b1;
                end
            end else if ((state == RAMP) && !abort_in) begin
                if (step_en) begin
                    tick_cnt   <= pre_q;
                    duty_cycle <= duty_nxt;
                    if (duty_nxt == target_q) begin
                        done <= 1'b1;
                    end
                end else begin
                    tick_cnt <= tick_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] duty_cycle;
    logic        busy;
    logic        done;
`ifdef PWM_RAMP_ABORT_EN
    logic        abort;
`endif

    int n_vec;
    int n_err;

    pwm_ramp_ctrl_if #(.BITS(16), .PRE_BITS(8)) ifc ();

    pwm_ramp_ctrl #(.BITS(16), .PRE_BITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (ifc.slave),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done)
`ifdef PWM_RAMP_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] t, input logic [15:0] s, input logic [7:0] p);
        @(negedge clk);
        ifc.cmd_target = t;
        ifc.cmd_step   = s;
        ifc.cmd_pre    = p;
        ifc.cmd_valid  = 1'b1;
        tick();
        ifc.cmd_valid  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n        = 1'b0;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_target = '0;
        ifc.cmd_step   = '0;
        ifc.cmd_pre    = '0;
`ifdef PWM_RAMP_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_duty", {16'h0, duty_cycle}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ready", {31'h0, ifc.cmd_ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Up ramp, step 4, one step per clock
        issue(16'h0010, 16'h0004, 8'd0);
        chk("t2_busy0", {31'h0, busy}, 32'h1);
        chk("t2_ready0", {31'h0, ifc.cmd_ready}, 32'h0);
        chk("t2_duty0", {16'h0, duty_cycle}, 32'h0);
        tick(); chk("t2_d1", {16'h0, duty_cycle}, 32'h4);
        tick(); chk("t2_d2", {16'h0, duty_cycle}, 32'h8);
        tick(); chk("t2_d3", {16'h0, duty_cycle}, 32'hC);
        chk("t2_done3", {31'h0, done}, 32'h0);
        chk("t2_busy3", {31'h0, busy}, 32'h1);
        tick(); chk("t2_d4", {16'h0, duty_cycle}, 32'h10);
        chk("t2_done4", {31'h0, done}, 32'h1);
        chk("t2_busy4", {31'h0, busy}, 32'h0);
        chk("t2_ready4", {31'h0, ifc.cmd_ready}, 32'h1);
        tick(); chk("t2_done5", {31'h0, done}, 32'h0);

        // Down ramp, step 5, every 3 clocks, clamps at 3
        issue(16'h0003, 16'h0005, 8'd2);
        tick(); chk("t3_hold1", {16'h0, duty_cycle}, 32'h10);
        tick(); chk("t3_hold2", {16'h0, duty_cycle}, 32'h10);
        tick(); chk("t3_d1", {16'h0, duty_cycle}, 32'h0B);
        tick(); chk("t3_hold3", {16'h0, duty_cycle}, 32'h0B);
        tick(); tick(); chk("t3_d2", {16'h0, duty_cycle}, 32'h06);
        chk("t3_done2", {31'h0, done}, 32'h0);
        tick(); tick(); tick(); chk("t3_d3", {16'h0, duty_cycle}, 32'h03);
        chk("t3_done3", {31'h0, done}, 32'h1);

        // Full-scale clamp without wrap
        issue(16'hC000, 16'hC000, 8'd0);
        tick(); chk("t4_pre", {16'h0, duty_cycle}, 32'hC000);
        issue(16'hFFFF, 16'h8000, 8'd0);
        tick(); chk("t4_clamp", {16'h0, duty_cycle}, 32'hFFFF);
        chk("t4_done", {31'h0, done}, 32'h1);
        issue(16'h0100, 16'hFFFF, 8'd0);
        tick(); chk("t4_down", {16'h0, duty_cycle}, 32'h0100);

        // Step 0 treated as 1; a held command waits until the ramp ends
        issue(16'h0102, 16'h0000, 8'd0);
        ifc.cmd_target = 16'h0105;
        ifc.cmd_step   = 16'h0005;
        ifc.cmd_pre    = 8'd0;
        ifc.cmd_valid  = 1'b1;
        tick(); chk("t5_d1", {16'h0, duty_cycle}, 32'h0101);
        chk("t5_ready1", {31'h0, ifc.cmd_ready}, 32'h0);
        tick(); chk("t5_d2", {16'h0, duty_cycle}, 32'h0102);
        chk("t5_done2", {31'h0, done}, 32'h1);
        chk("t5_ready2", {31'h0, ifc.cmd_ready}, 32'h1);
        tick(); chk("t5_acc_busy", {31'h0, busy}, 32'h1);
        chk("t5_acc_duty", {16'h0, duty_cycle}, 32'h0102);
        ifc.cmd_valid = 1'b0;
        tick(); chk("t5_d3", {16'h0, duty_cycle}, 32'h0105);
        chk("t5_done3", {31'h0, done}, 32'h1);

        // Target equals current duty
        issue(16'h0105, 16'h0010, 8'd0);
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_done", {31'h0, done}, 32'h1);
        chk("t6_duty", {16'h0, duty_cycle}, 32'h0105);
        tick(); chk("t6_done_off", {31'h0, done}, 32'h0);

        // Async reset mid-ramp at 0x4000
        issue(16'h0000, 16'hFFFF, 8'd0);
        tick(); chk("t1_zero", {16'h0, duty_cycle}, 32'h0);
        issue(16'h8000, 16'h4000, 8'd1);
        tick(); tick(); chk("t1_mid", {16'h0, duty_cycle}, 32'h4000);
        chk("t1_mid_busy", {31'h0, busy}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_duty", {16'h0, duty_cycle}, 32'h0);
        chk("t1_busy", {31'h0, busy}, 32'h0);
        chk("t1_ready", {31'h0, ifc.cmd_ready}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef PWM_RAMP_ABORT_EN
        issue(16'h0010, 16'h0008, 8'd0);
        tick(); chk("ab_d1", {16'h0, duty_cycle}, 32'h0008);
        abort = 1'b1;
        tick(); chk("ab_duty", {16'h0, duty_cycle}, 32'h0008);
        chk("ab_busy", {31'h0, busy}, 32'h0);
        chk("ab_done", {31'h0, done}, 32'h0);
        chk("ab_ready", {31'h0, ifc.cmd_ready}, 32'h1);
        tick(); chk("ab_hold", {16'h0, duty_cycle}, 32'h0008);
        issue(16'h0009, 16'h0001, 8'd0);
        chk("ab_idle_acc", {31'h0, busy}, 32'h1);
        abort = 1'b0;
        tick(); chk("ab_d2", {16'h0, duty_cycle}, 32'h0009);
        chk("ab_done2", {31'h0, done}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
